mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one `bram32` instance between the CPU instruction-fetch port and the CPU data port, so a unified program/data memory can replace the split I/D BRAM pair. Data reads win the single read port by default, and a starvation counter guarantees forward progress of fetch. Writes bypass arbitration on the BRAM write port. The block raises a fetch stall toward the CPU's `pc_stall` logic whenever a fetch is not granted.

## Interface
- `ADDR_WIDTH`, default 12: word address width (`RAM_ADDR_WIDTH`).
- `DATA_WIDTH`, default 32: word width.
- `MAX_WAIT`, default 4: consecutive denied fetch cycles before fetch is forced to win; range 1..15.
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch read request.
- `i_addr` in ADDR_WIDTH: fetch word address.
- `i_gnt` out 1: fetch accepted this cycle (combinational).
- `i_rvalid` out 1: `i_rdata` is valid this cycle.
- `i_rdata` out DATA_WIDTH: fetched word.
- `i_stall` out 1: `i_req & ~i_gnt`; feeds the CPU stall input.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_WIDTH: data word address.
- `d_wdat` in DATA_WIDTH: write data.
- `d_be` in 4: byte enables for writes.
- `d_gnt` out 1: data request accepted this cycle (combinational).
- `d_rvalid` out 1: `d_rdata` is valid.
- `d_rdata` out DATA_WIDTH: read word.
- `m_r_addr` out ADDR_WIDTH, `m_r_enb` out 1, `m_r_dat` in DATA_WIDTH: BRAM read port.
- `m_w_addr` out ADDR_WIDTH, `m_w_dat` out DATA_WIDTH, `m_w_enb` out 1, `m_byte_enb` out 4: BRAM write port.

## Operation
**Data writes**
- A data write (`d_req & d_we`) is always granted: `d_gnt = 1`.
- It drives the write port directly: `m_w_enb = 1`, and `m_byte_enb = d_be`.
- It never uses the read port and never produces `d_rvalid`.

**Read-port arbitration** between a data read (`d_req & ~d_we`) and a fetch (`i_req`):
- Only one requester present: that requester is granted.
- Both present and `wait_cnt < MAX_WAIT`: the data read is granted and the fetch is denied.
- Both present and `wait_cnt == MAX_WAIT`: the fetch is granted and the data read is denied (`d_gnt = 0`; the CPU holds its request).

**Write-collision rule**
- A fetch whose `i_addr` equals `m_w_addr` while `m_w_enb = 1` is denied that cycle, independent of `wait_cnt`.
- There is no read/write forwarding; the fetch retries and reads the new data the next cycle.

**wait_cnt** (4 bits)
- Increments on every cycle with `i_req & ~i_gnt`, saturating at `MAX_WAIT`.
- Clears on any cycle with `i_gnt`, or with `~i_req`.

**Return tracking**
- Register `owner` takes the values NONE, IFETCH or DATA.
- It is loaded each cycle with the winner of the read port, or NONE if the read port is unused.
- Next cycle: `owner == IFETCH` gives `i_rvalid = 1` and `i_rdata = m_r_dat`; `owner == DATA` gives `d_rvalid = 1` and `d_rdata = m_r_dat`.
- The read port is fully pipelined: a new grant is allowed every cycle while the previous return is delivered.

**Outputs and reset**
- `m_r_enb` equals the read-port grant; `m_r_addr` carries the winner's address, and 0 when idle.
- `i_rdata` and `d_rdata` show `m_r_dat` every cycle; they are meaningful only while the matching `rvalid` is high.
- Reset: `owner = NONE` and `wait_cnt = 0`, so `i_rvalid = d_rvalid = 0` on the cycle after reset.
- Grant outputs are forced to 0 while `rst = 1`, which also forces all `m_*` enables to 0.
- A read granted in the cycle `rst` rises is dropped and produces no `rvalid`.

## Timing
- Grant: same cycle as the request (combinational from `req`, `addr`, `wait_cnt`).
- Read latency: `rvalid` exactly 1 cycle after the grant, matching the registered BRAM read.
- Write: committed at the edge ending the grant cycle.
- Worst-case fetch wait under continuous data reads: `MAX_WAIT` cycles, then granted in cycle `MAX_WAIT + 1`.
- Simultaneous data write and fetch to different addresses: both granted in the same cycle.
- Back-to-back data read then fetch: `d_rvalid` in cycle n+1 and `i_rvalid` in cycle n+2, with no bubble.

## Structure
- Shared package / include `rv32i_params.vh`: `RAM_ADDR_WIDTH`, `DATA_WIDTH`.
- The owner encoding (`OWN_NONE = 2'd0`, `OWN_I = 2'd1`, `OWN_D = 2'd2`) goes in `rv32i_control.vh`.
- One natural sub-module, `starve_counter`: the saturating `wait_cnt` with `inc`/`clr` inputs and an `at_max` output.
- The rest is flat: grant logic plus the `owner` register.

## Test plan
- Reset behaviour:
  - Hold `rst` 2 cycles with `i_req = d_req = 1`: all `gnt`, `rvalid` and `m_*_enb` are 0.
  - First cycle after release: `i_gnt = 1` only if `d_req = 0`.
- Fetch alone:
  - Stimulus: `i_req`, `i_addr = 0x004`, memory word = 0x00500093.
  - Required: `i_gnt` in cycle n, `i_rvalid = 1` with `i_rdata = 0x00500093` in cycle n+1, `i_stall` stays 0.
- Contention with `MAX_WAIT = 4`:
  - Stimulus: `d_req` read and `i_req` both held high.
  - Required: `d_gnt` for 4 cycles with `i_stall = 1`, then in cycle 5 `i_gnt = 1` and `d_gnt = 0`, then `wait_cnt` returns to 0.
- Write collision:
  - Stimulus: `d_we = 1`, `d_addr = 0x010`, `d_wdat = 0xDEADBEEF`, `d_be = 0xF`, plus `i_req` to `0x010` in the same cycle.
  - Required: fetch denied.
  - Next cycle: fetch granted, and `i_rdata` one cycle later = 0xDEADBEEF.
- Parallel write and fetch:
  - Stimulus: write to 0x020 with `d_be = 0x3`, fetch of 0x008, same cycle.
  - Required: both granted, only the low 2 bytes of 0x020 change, and `i_rvalid` arrives next cycle.
- Reset mid-read:
  - Stimulus: data read granted in cycle n, `rst = 1` in cycle n.
  - Required: `d_rvalid = 0` in cycle n+1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared memory widths and read-return owner encoding
package mem_port_arbiter_pkg;
  localparam int RAM_ADDR_WIDTH = 12;
  localparam int RAM_DATA_WIDTH = 32;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;
endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// starve_counter: saturating count of consecutive denied fetch cycles
module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [3:0] cnt_q, cnt_d;
  assign at_max = cnt_q == 4'(MAX_WAIT);
  always_comb cnt_d = clr ? 4'd0 : (inc && !at_max) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one bram32 read/write port pair between fetch and data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdat,
  input  logic [3:0]            d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] m_r_addr,
  output logic                  m_r_enb,
  input  logic [DATA_WIDTH-1:0] m_r_dat,
  output logic [ADDR_WIDTH-1:0] m_w_addr,
  output logic [DATA_WIDTH-1:0] m_w_dat,
  output logic                  m_w_enb,
  output logic [3:0]            m_byte_enb
);
  owner_e owner_q, owner_d;
  logic   at_max, wr, d_rd_req, i_ok, d_rd_gnt;
  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (i_stall),
    .clr    (!i_stall),
    .at_max (at_max)
  );
  always_comb begin
    wr       = !rst && d_req && d_we;
    d_rd_req = !rst && d_req && !d_we;
    i_ok     = !rst && i_req && !(wr && i_addr == d_addr);
    i_gnt    = i_ok && (!d_rd_req || at_max);
    d_rd_gnt = d_rd_req && !i_gnt;
    d_gnt    = wr || d_rd_gnt;
    i_stall  = i_req && !i_gnt;
    m_r_enb  = i_gnt || d_rd_gnt;
    m_r_addr = i_gnt ? i_addr : d_rd_gnt ? d_addr : '0;
    owner_d  = i_gnt ? OWN_I : d_rd_gnt ? OWN_D : OWN_NONE;
  end
  assign m_w_enb    = wr;
  assign m_w_addr   = d_addr;
  assign m_w_dat    = d_wdat;
  assign m_byte_enb = d_be;
  assign i_rvalid   = owner_q == OWN_I;
  assign d_rvalid   = owner_q == OWN_D;
  assign i_rdata    = m_r_dat;
  assign d_rdata    = m_r_dat;
  always_ff @(posedge clk) owner_q <= rst ? OWN_NONE : owner_d;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed scoreboard check of mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;
  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
  } exp_t;
  logic          clk = 0;
  logic          rst, i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, m_r_addr, m_w_addr;
  logic [DW-1:0] d_wdat, i_rdata, d_rdata, m_r_dat, m_w_dat;
  logic [3:0]    d_be, m_byte_enb;
  logic          i_gnt, i_rvalid, i_stall, d_gnt, d_rvalid, m_r_enb, m_w_enb;
  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  exp_t          iq[$];
  exp_t          dq[$];
  int            cyc = 0;
  int            starve = 0;
  int            vectors = 0;
  int            errs = 0;
  logic          mon_en = 0;
  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdat(d_wdat), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_r_addr(m_r_addr), .m_r_enb(m_r_enb), .m_r_dat(m_r_dat),
    .m_w_addr(m_w_addr), .m_w_dat(m_w_dat), .m_w_enb(m_w_enb), .m_byte_enb(m_byte_enb)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (m_r_enb) m_r_dat <= mem[m_r_addr];
    if (m_w_enb)
      for (int b = 0; b < 4; b++)
        if (m_byte_enb[b]) mem[m_w_addr][8*b +: 8] <= m_w_dat[8*b +: 8];
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia, input logic dr,
                      input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                      input logic [3:0] be);
    logic wr, rd, ifx, eig, edr;
    @(negedge clk);
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdat = wd; d_be = be;
    #2;
    wr  = !r && dr && dw;
    rd  = !r && dr && !dw;
    ifx = !r && ir && !(wr && ia == da);
    eig = ifx && (!rd || starve >= MW);
    edr = rd && !eig;
    chk("i_gnt", i_gnt, eig);
    chk("d_gnt", d_gnt, wr || edr);
    chk("i_stall", i_stall, ir && !eig);
    chk("m_r_enb", m_r_enb, eig || edr);
    chk("m_r_addr", m_r_addr, eig ? ia : edr ? da : '0);
    chk("m_w_enb", m_w_enb, wr);
    if (wr) chk("m_byte_enb", m_byte_enb, be);
    if (eig) iq.push_back('{cyc + 1, ref_mem[ia]});
    if (edr) dq.push_back('{cyc + 1, ref_mem[da]});
    if (wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
    starve = (r || !ir || eig) ? 0 : (starve < MW ? starve + 1 : MW);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, 0, '0, '0, 4'h0);
  endtask
  initial begin
    exp_t e;
    logic due;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      due = iq.size() > 0 && iq[0].cyc <= cyc;
      chk("i_rvalid", i_rvalid, due);
      if (due) begin
        e = iq.pop_front();
        if (i_rvalid) chk("i_rdata", i_rdata, e.dat);
      end
      due = dq.size() > 0 && dq[0].cyc <= cyc;
      chk("d_rvalid", d_rvalid, due);
      if (due) begin
        e = dq.pop_front();
        if (d_rvalid) chk("d_rdata", d_rdata, e.dat);
      end
    end
  end
  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h0050_0093;
    ref_mem[4] = 32'h0050_0093;
    step(1, 1, 12'h004, 1, 0, 12'h100, '0, 4'h0);
    step(1, 1, 12'h004, 1, 0, 12'h100, '0, 4'h0);
    mon_en = 1;
    step(0, 1, 12'h004, 0, 0, '0, '0, 4'h0);
    idle(2);
    for (int k = 0; k < 7; k++) step(0, 1, 12'h104, 1, 0, 12'h100 + 12'(k), '0, 4'h0);
    idle(1);
    for (int k = 0; k < 6; k++) step(0, 1, 12'h204, 1, 0, 12'h200 + 12'(k), '0, 4'h0);
    idle(2);
    step(0, 1, 12'h010, 1, 1, 12'h010, 32'hDEAD_BEEF, 4'hF);
    step(0, 1, 12'h010, 0, 0, '0, '0, 4'h0);
    idle(2);
    step(0, 1, 12'h008, 1, 1, 12'h020, 32'h1234_5678, 4'h3);
    step(0, 0, '0, 1, 0, 12'h020, '0, 4'h0);
    idle(2);
    step(0, 0, '0, 1, 0, 12'h030, '0, 4'h0);
    step(1, 0, '0, 1, 0, 12'h030, '0, 4'h0);
    step(0, 0, '0, 0, 0, '0, '0, 4'h0);
    idle(2);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, 12'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 12'($urandom_range(0, 15)),
           $urandom, 4'($urandom));
    idle(4);
    chk("i_queue_drained", 64'(iq.size()), 64'd0);
    chk("d_queue_drained", 64'(dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
